// File: rtl/sta_seq_pkg.sv
// Shared types and helpers for the word-serial spanning-tree-adder sequencer.
package sta_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned k);
        int unsigned w;
        w = 1;
        if (k > 1) w = $clog2(k);
        return w;
    endfunction

endpackage

// File: rtl/spanning_tree_adder.sv
// N-bit parallel-prefix (Kogge-Stone style) adder with carry-in; purely combinational.
module spanning_tree_adder #(
    parameter int N = 8
) (
    input  logic         CLOCK_50,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    // Clock is part of the shared interface but the datapath is combinational.
    logic unused_clk;
    assign unused_clk = CLOCK_50;

    logic [N-1:0] p;
    logic [N-1:0] gg;
    logic [N-1:0] pp;
    logic [N-1:0] ng;
    logic [N-1:0] np;
    logic [N:0]   c;

    always_comb begin
        p  = a ^ b;
        gg = a & b;
        pp = p;
        ng = '0;
        np = '0;
        for (int unsigned d = 1; d < N; d = d * 2) begin
            ng = gg;
            np = pp;
            for (int unsigned i = d; i < N; i++) begin
                ng[i] = gg[i] | (pp[i] & gg[i-d]);
                np[i] = pp[i] & pp[i-d];
            end
            gg = ng;
            pp = np;
        end
        c = {gg | (pp & {N{cin}}), cin};
    end

    assign sum  = p ^ c[N-1:0];
    assign cout = c[N];

endmodule

// File: rtl/sta_word_sequencer.sv
// W = N*K adder that reuses one N-bit spanning_tree_adder over K slices, LSW first.
// Optional subtraction is enabled by defining STA_SEQ_SUB_EN.
module sta_word_sequencer
    import sta_seq_pkg::*;
#(
    parameter int N = 8,
    parameter int K = 4
) (
    input  logic           CLOCK_50,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*K-1:0] a,
    input  logic [N*K-1:0] b,
    input  logic           cin,
`ifdef STA_SEQ_SUB_EN
    input  logic           op_sub,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*K-1:0] sum,
    output logic           cout,
    output logic           ovf,
    output logic           zero,
    output logic           busy
);

    localparam int W = N * K;
    localparam int unsigned CW = cnt_width(K);

    state_t          state, state_nxt;
    logic [W-1:0]    a_q, b_q, res_q;
    logic            carry_q;
    logic [CW-1:0]   k_q;
    logic            sub_q;
    logic            in_sub;
    logic            accept;
    logic [N-1:0]    sl_sum;
    logic            sl_cout;
    logic            msb_cin;

`ifdef STA_SEQ_SUB_EN
    assign in_sub = op_sub;
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n)      sub_q <= 1'b0;
        else if (accept) sub_q <= op_sub;
    end
`else
    assign in_sub = 1'b0;
    assign sub_q  = 1'b0;
`endif

    spanning_tree_adder #(.N(N)) u_sta (
        .CLOCK_50 (CLOCK_50),
        .a        (a_q[k_q*N +: N]),
        .b        (b_q[k_q*N +: N]),
        .cin      (carry_q),
        .sum      (sl_sum),
        .cout     (sl_cout)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (k_q == CW'(K - 1)) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;

    // Subtraction is folded into the capture: B is inverted and the borrow-in becomes a carry-in.
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b ^ {W{in_sub}};
            res_q   <= '0;
            carry_q <= cin ^ in_sub;
            k_q     <= '0;
        end else if (state == RUN) begin
            res_q[k_q*N +: N] <= sl_sum;
            carry_q           <= sl_cout;
            k_q               <= k_q + CW'(1);
        end
    end

    assign msb_cin = a_q[W-1] ^ b_q[W-1] ^ res_q[W-1];

    assign sum  = out_valid ? res_q : '0;
    assign cout = out_valid & (carry_q ^ sub_q);
    assign ovf  = out_valid & (msb_cin ^ carry_q);
    assign zero = out_valid & ~|res_q;
    assign busy = (state != IDLE);

endmodule

// File: doc/sta_word_sequencer.md
# sta_word_sequencer

Multi-cycle sequencer that performs W = N·K-bit additions (and optionally subtractions) by time-multiplexing one N-bit spanning-tree adder over K word slices, least-significant word first, chaining the carry through a register. It sits between an operand producer (e.g. the FPU mantissa/exponent path) and its consumer. It provides valid/ready handshakes on both sides, so a single narrow prefix adder can serve wide operands at one slice per cycle.

## Interface
- `N`, 8: slice width; width of the shared adder instance (N ≥ 2)
- `K`, 4: number of slices per operation (K ≥ 1); W = N·K
- `CLOCK_50`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `in_valid`  in  1  operand request
- `in_ready`  out  1  sequencer can accept operands
- `a`  in  W  operand A
- `b`  in  W  operand B
- `cin`  in  1  carry-in (add) / borrow-in (sub)
- `op_sub`  in  1  1 = A − B − cin; port present only with STA_SEQ_SUB_EN
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer accepts result
- `sum`  out  W  result
- `cout`  out  1  carry-out (add) / borrow-out (sub)
- `ovf`  out  1  two's-complement signed overflow
- `zero`  out  1  sum == 0
- `busy`  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid && in_ready`, latch `a` and `b'`, where `b'` = `op_sub ? ~b : b`.
  - Carry register ← `op_sub ? ~cin : cin`. Slice counter ← 0. Result register ← 0. Go to RUN.
- RUN, one slice per cycle:
  - Adder inputs: A[k·N +: N], B'[k·N +: N], Cin = carry register.
  - Result[k·N +: N] ← Sum. Carry register ← Cout. k ← k+1.
  - When k == K−1, go to DONE after the write.
- DONE:
  - `out_valid` = 1; `sum` = result register.
  - `cout` = final carry XOR `op_sub`.
  - `ovf` = carry into MSB XOR carry out of MSB. Carry into MSB = A[W−1] ^ B'[W−1] ^ sum[W−1].
  - `zero` = ~|sum.
  - On `out_valid && out_ready`, go to IDLE.
- `in_valid` outside IDLE is ignored; operands are not captured.
- `out_ready` outside DONE is ignored.
- K = 1: RUN lasts exactly one cycle.
- Arithmetic is modulo 2^W. No sign extension and no saturation.

## Timing
- All outputs reset to 0 except `in_ready` = 1 (state IDLE). Counter, carry, and result registers reset to 0.
- Reset asserted in any state, including mid-RUN: the next cycle is IDLE and the in-flight operation is discarded.
- Latency: accept edge E0 → `out_valid` high in the cycle after edge E0+K, i.e. K cycles after accept.
- `out_valid`, `sum`, and flags hold stable while `out_ready` = 0.
- `in_ready` re-asserts the cycle after the output handshake. There is no same-cycle bypass.
- Maximum throughput is one operation per K+2 cycles.
- The adder path is combinational within a RUN cycle. Critical path: carry register → STA → result/carry registers.

## Configuration
- `STA_SEQ_SUB_EN` defined:
  - `op_sub` port exists and is latched at accept.
  - Subtraction is computed as A + ~B + ~cin.
  - `cout` reports borrow.
- `STA_SEQ_SUB_EN` undefined:
  - No `op_sub` port; the design is add-only.
  - `b'` = `b`, initial carry = `cin`, `cout` = final carry.

## Structure
- Shared package `sta_seq_pkg`:
  - FSM state typedef (IDLE/RUN/DONE).
  - Localparam for state encoding.
  - Helper function for counter width ($clog2(K), minimum 1).
- Sub-module: a single instance of the existing `spanning_tree_adder #(.N(N))` as the shared datapath.
  - Its `CLOCK_50` input is tied to this block's `CLOCK_50`.
  - It has no other sub-modules.

## Test plan
1. N=8, K=4; a=0x000000FF, b=0x00000001, cin=0 → sum=0x00000100, cout=0, ovf=0, zero=0; `out_valid` exactly 4 cycles after accept.
2. a=0xFFFFFFFF, b=0x00000001, cin=0 → sum=0x00000000, cout=1, zero=1, ovf=0 (carry ripples through all four slices).
3. a=0x7FFFFFFF, b=0x00000001 → sum=0x80000000, ovf=1, cout=0.
4. With `STA_SEQ_SUB_EN`: a=5, b=7, cin=0, op_sub=1 → sum=0xFFFFFFFE, cout(borrow)=1, ovf=0. Also a=7, b=7 → sum=0, zero=1, cout=0.
5. Backpressure: `out_ready`=0 for 10 cycles in DONE → sum/flags stable, `in_ready`=0, a concurrent `in_valid` with new operands is not captured. Raising `out_ready` → IDLE the next cycle.
6. Reset: `rst_n`=0 during RUN slice 2 → next cycle `in_ready`=1, `out_valid`=0, sum=0. A following operation (a=1, b=2) returns sum=3.
